// File: rtl/fifo_wr_ctrl_param_if.sv
// Write-side bundle of the dual-clock FIFO: producer request, synchronised read
// pointer, RAM write port and the status flags produced by fifo_wr_ctrl_param.
interface fifo_wr_ctrl_param_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W:0]   g_rd_ptr_sync;
    logic              ovf_clr;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   b_wr_ptr;
    logic [ADDR_W:0]   g_wr_ptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en, g_rd_ptr_sync, ovf_clr,
        input  mem_we, wr_addr, b_wr_ptr, g_wr_ptr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, g_rd_ptr_sync, ovf_clr,
        output mem_we, wr_addr, b_wr_ptr, g_wr_ptr, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl_param.sv
// Write-domain controller of a dual-clock FIFO: binary/Gray write pointers, RAM strobe,
// full/almost-full, fill level. Define FIFO_WR_OVF_EN to build the sticky overflow flag.
module fifo_wr_ctrl_param #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 2
) (
    input logic                wclk,
    input logic                wrst_n,
    fifo_wr_ctrl_param_if.slave bus
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);

    logic [PW-1:0] b_wr_ptr_q, b_wr_ptr_d;
    logic [PW-1:0] g_wr_ptr_q, g_wr_ptr_d;
    logic [PW-1:0] wr_level_q, wr_level_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic [PW-1:0] b_rd;
    logic [PW-1:0] g_rd_full;
    logic [PW-1:0] free_slots;
    logic          push;

    // Each binary bit is the XOR of all Gray bits from the MSB down to that position.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign b_rd[gi] = ^(bus.g_rd_ptr_sync >> gi);
        end
    endgenerate

    // Full when the write pointer sits exactly one lap ahead of the read pointer.
    assign g_rd_full = {~bus.g_rd_ptr_sync[ADDR_W:ADDR_W-1], bus.g_rd_ptr_sync[ADDR_W-2:0]};

    always_comb begin
        push          = bus.wr_en & ~full_q;
        b_wr_ptr_d    = b_wr_ptr_q + PW'(push);
        g_wr_ptr_d    = b_wr_ptr_d ^ (b_wr_ptr_d >> 1);
        full_d        = (g_wr_ptr_d == g_rd_full);
        wr_level_d    = b_wr_ptr_d - b_rd;
        free_slots    = DEPTH_P - wr_level_d;
        almost_full_d = (free_slots <= AF_P);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wr_ptr_q    <= '0;
            g_wr_ptr_q    <= '0;
            wr_level_q    <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            b_wr_ptr_q    <= b_wr_ptr_d;
            g_wr_ptr_q    <= g_wr_ptr_d;
            wr_level_q    <= wr_level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
        end
    end

    // The strobe is masked during reset so no RAM write escapes while pointers are held.
    assign bus.mem_we      = push & wrst_n;
    assign bus.wr_addr     = b_wr_ptr_q[ADDR_W-1:0];
    assign bus.b_wr_ptr    = b_wr_ptr_q;
    assign bus.g_wr_ptr    = g_wr_ptr_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.wr_level    = wr_level_q;

`ifdef FIFO_WR_OVF_EN
    logic overflow_q, overflow_d;

    // A rejected write on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.ovf_clr)
            overflow_d = 1'b0;
        if (bus.wr_en & full_q)
            overflow_d = 1'b1;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            overflow_q <= 1'b0;
        else
            overflow_q <= overflow_d;
    end

    assign bus.overflow = overflow_q;
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = bus.ovf_clr;
    assign bus.overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl_param.sv
// Randomised bench for fifo_wr_ctrl_param (ADDR_W=3, AF_THRESH=2) against a
// counter-based FIFO model; honours FIFO_WR_OVF_EN when defined.
module tb_fifo_wr_ctrl_param;
`ifdef FIFO_WR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic wclk;
    logic wrst_n;
    logic [7:0] wdata;

    fifo_wr_ctrl_param_if #(.ADDR_W(3)) bus ();

    fifo_wr_ctrl_param #(.ADDR_W(3), .AF_THRESH(2)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // External RAM driven by the controller's write port.
    logic [7:0] ram [8];
    always @(posedge wclk)
        if (bus.mem_we)
            ram[bus.wr_addr] <= wdata;

    // Reference model: total writes accepted and total reads, as plain counters.
    int         wr_cnt;
    int         rd_cnt;
    bit         m_full;
    bit         m_ovf;
    logic [7:0] mdl [8];

    int vec_cnt;
    int err_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] ram_flat();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = ram[i];
        return v;
    endfunction

    function automatic logic [63:0] mdl_flat();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    task automatic check_regs();
        int lvl;
        lvl = wr_cnt - rd_cnt;
        check_val("b_wr_ptr",    bus.b_wr_ptr,    64'(wr_cnt % 16));
        check_val("g_wr_ptr",    bus.g_wr_ptr,    64'(gray(wr_cnt)));
        check_val("wr_level",    bus.wr_level,    64'(lvl));
        check_val("full",        bus.full,        64'(lvl == 8));
        check_val("almost_full", bus.almost_full, 64'((8 - lvl) <= 2));
        check_val("overflow",    bus.overflow,    64'(m_ovf));
        check_val("ram",         ram_flat(),      mdl_flat());
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One write-clock cycle: drive at the falling edge, check the strobe, then the registers.
    task automatic step(input bit we, input bit clr);
        bit exp_push;
        @(negedge wclk);
        bus.wr_en         = we;
        bus.ovf_clr       = clr;
        bus.g_rd_ptr_sync = gray(rd_cnt);
        wdata             = 8'($urandom);
        #1;
        exp_push = we && !m_full;
        check_val("mem_we",  bus.mem_we,  64'(exp_push));
        check_val("wr_addr", bus.wr_addr, 64'(wr_cnt % 8));
        @(posedge wclk);
        if (OVF_ON) begin
            if (we && m_full)
                m_ovf = 1'b1;
            else if (clr)
                m_ovf = 1'b0;
        end
        if (exp_push) begin
            mdl[wr_cnt % 8] = wdata;
            wr_cnt++;
        end
        m_full = (wr_cnt - rd_cnt) == 8;
        #1;
        check_regs();
        $display("cyc we=%0b clr=%0b rd=%0d wr=%0d lvl=%0d full=%0b af=%0b ovf=%0b",
                 we, clr, rd_cnt, wr_cnt, bus.wr_level, bus.full, bus.almost_full, bus.overflow);
    endtask

    initial begin
        bit   wrap_seen;
        logic [3:0] prev_b;
        vec_cnt = 0;
        err_cnt = 0;
        wrap_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'h00;
            mdl[i] = 8'h00;
        end
        model_reset();
        wrst_n            = 1'b0;
        bus.wr_en         = 1'b0;
        bus.ovf_clr       = 1'b0;
        bus.g_rd_ptr_sync = 4'b0000;
        wdata             = 8'h00;

        // Power-on reset, then release between edges.
        repeat (2) @(posedge wclk);
        #1;
        check_regs();
        check_val("rst_mem_we", bus.mem_we, 64'd0);
        #1 wrst_n = 1'b1;

        // A few writes, then a mid-stream reset with wr_en held high.
        repeat (3) step(1'b1, 1'b0);
        bus.wr_en = 1'b1;
        #2 wrst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_val("rst_mem_we", bus.mem_we,  64'd0);
        check_val("rst_wr_addr", bus.wr_addr, 64'd0);
        @(posedge wclk);
        #2 wrst_n = 1'b1;

        // Fill from empty: eight consecutive writes.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (i == 5) begin
                check_val("lvl_after6", bus.wr_level,    64'd6);
                check_val("af_after6",  bus.almost_full, 64'd1);
            end
        end
        check_val("b_full",   bus.b_wr_ptr, 64'h8);
        check_val("g_full",   bus.g_wr_ptr, 64'hC);
        check_val("full_set", bus.full,     64'd1);
        check_val("lvl_full", bus.wr_level, 64'd8);

        // Writes while full and overflow set/clear behaviour.
        step(1'b1, 1'b0);
        check_val("ptr_hold", bus.b_wr_ptr, 64'h8);
        check_val("ovf_set",  bus.overflow, 64'(OVF_ON));
        step(1'b0, 1'b1);
        check_val("ovf_clr",  bus.overflow, 64'd0);
        step(1'b1, 1'b1);
        check_val("ovf_setwins", bus.overflow, 64'(OVF_ON));

        // Read pointer jumps to 4 while full.
        rd_cnt = 4;
        step(1'b0, 1'b0);
        check_val("full_drop", bus.full,        64'd0);
        check_val("lvl_drop",  bus.wr_level,    64'd4);
        check_val("af_drop",   bus.almost_full, 64'd0);

        // Read side tracking one entry per cycle through a pointer wrap.
        for (int i = 0; i < 20; i++) begin
            prev_b = bus.b_wr_ptr;
            if (rd_cnt < wr_cnt) rd_cnt++;
            step(1'b1, 1'b0);
            if (prev_b == 4'hF) begin
                wrap_seen = 1'b1;
                check_val("wrap_b", bus.b_wr_ptr, 64'h0);
                check_val("wrap_g", bus.g_wr_ptr, 64'h0);
            end
        end
        check_val("wrap_seen", 64'(wrap_seen), 64'd1);

        // Random producer traffic against legal single-step read advances.
        for (int i = 0; i < 500; i++) begin
            if (($urandom % 3) == 0 && rd_cnt < wr_cnt) rd_cnt++;
            step(($urandom % 4) != 0, ($urandom % 16) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
